csa_sub_pipe: RTL and testbench
===============================

// Module: csa_sub_pipe
// PURPOSE
//  Pipelined carry-select subtractor (diff = i_sub_term1 - i_sub_term2), the inverse-direction companion of the csa adder family.
//  Two-stage valid/ready pipeline: stage 1 forms block differences for both carry-ins; stage 2 ripples the block carries and muxes.
//  Feeds batch adder/subtractor characterisation; one operation accepted per cycle when not back-pressured.
// PARAMETERS
//  WIDTH  5  operand/result width in bits (>= 2)
//  BLK    2  carry-select block width; lowest block is plain ripple, remaining WIDTH-BLK bits split into BLK-wide blocks (last may be short)
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      synchronous, active-high reset
//  in_valid      in   1      operand pair valid
//  in_ready      out  1      block can accept operand pair this cycle
//  i_sub_term1   in   WIDTH  minuend (unsigned, or two's complement under OVF_FLAG_EN)
//  i_sub_term2   in   WIDTH  subtrahend
//  out_valid     out  1      diff/borrow valid
//  out_ready     in   1      downstream accepts result
//  diff          out  WIDTH  (term1 - term2) mod 2^WIDTH
//  borrow        out  1      1 when term1 < term2 (unsigned), = ~carry-out of term1 + ~term2 + 1
//  ovf           out  1      present only with OVF_FLAG_EN: signed overflow
// BEHAVIOUR
//  - Arithmetic: diff = term1 + ~term2 + 1; lowest block uses cin=1; each upper block computes {cout,sum} for cin=0 and cin=1.
//  - Stage 1 registers: low-block sum + carry, per-block sum0/sum1/cout0/cout1, s1_valid, plus term1/term2 MSBs (for ovf).
//  - Stage 2 registers: selected diff, borrow = ~final carry, ovf, s2_valid; out_valid = s2_valid.
//  - Latency exactly 2 cycles from accepted input (in_valid & in_ready) to out_valid with no back-pressure.
//  - Advance rules: s2_adv = ~s2_valid | out_ready; s1_adv = ~s1_valid | s2_adv; in_ready = s1_adv (combinational, no in_valid dependence).
//  - Stage holds its data unchanged while not advancing; out data stable while out_valid & ~out_ready.
//  - Full throughput: out_ready held 1 -> one result per cycle, no bubbles.
//  - Empty: in_valid=0 & stage advances -> stage valid clears, data don't-care (hold old value allowed).
//  - Full: both stages valid, out_ready=0 -> in_ready=0; input ignored even if in_valid=1.
//  - Simultaneous: s2 drain + s1 move + new accept in same cycle is legal and must not drop/duplicate.
//  - Reset (any time, incl. mid-operation): s1_valid=s2_valid=0, diff=0, borrow=0, ovf=0; in-flight ops discarded; in_ready=1 cycle after reset.
//  - No state machine beyond the two valid bits; no X may reach diff while out_valid=1.
// CONFIGURATION
//  OVF_FLAG_EN defined: ovf port exists; ovf = (t1[W-1]!=t2[W-1]) & (diff[W-1]!=t1[W-1]), registered with diff.
//  OVF_FLAG_EN undefined: no ovf port, no MSB pipeline registers; all other behaviour identical.
// STRUCTURE
//  Package csa_pkg: CSA_WIDTH_DEF=5, CSA_BLK_DEF=2, function csa_nblk(width,blk) giving upper-block count.
//  Sub-module csa_sub_blk (combinational, param BW): inputs a,b_inv[BW]; outputs sum0,sum1[BW], cout0,cout1;
//   instantiated once per upper block via generate; lowest block = csa_sub_blk with sum1/cout1 used.
//  Top holds only pipeline registers, handshake logic and stage-2 select chain.
// TESTING (WIDTH=5, BLK=2, out_ready=1 unless stated)
//  1 9-3 -> 2 cycles later diff=6, borrow=0.
//  2 3-9 -> diff=26 (5'b11010), borrow=1; 0-0 -> diff=0, borrow=0; 31-31 -> 0, borrow=0.
//  3 OVF_FLAG_EN: 16-1 (-16-1) -> diff=15, ovf=1; 15-(-1)=15-31 -> diff=16, ovf=1; 5-3 -> ovf=0.
//  4 Back-pressure: stream 4 ops, out_ready=0 for 3 cycles after first result -> in_ready drops after 2 accepted,
//    diff held stable, all 4 results emerge in order with none lost/duplicated.
//  5 Reset mid-stream: assert rst with both stages valid -> next cycle out_valid=0, diff=0, in_ready=1; next op 7-2 -> 5.
//  6 Exhaustive random: all 1024 operand pairs, random in_valid/out_ready -> scoreboard vs (a-b)&31, borrow=(a<b).

Source files
------------

// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared constants and helpers for the carry-select adder/subtractor family.
//   CSA_WIDTH_DEF : default operand width
//   CSA_BLK_DEF   : default carry-select block width
//   csa_nblk()    : number of carry-select blocks above the low ripple block
// ---------------------------------------------------------------------------
package csa_pkg;

    localparam int CSA_WIDTH_DEF = 5;
    localparam int CSA_BLK_DEF   = 2;

    // The low BLK bits form a plain ripple block; whatever is left above it is
    // split into BLK-wide blocks, the top one possibly short.
    function automatic int csa_nblk(input int width, input int blk);
        if (width <= blk) begin
            return 0;
        end
        return (width - blk + blk - 1) / blk;
    endfunction

endpackage

// File: rtl/csa_sub_blk.sv
// ---------------------------------------------------------------------------
// csa_sub_blk
// Combinational carry-select block: adds a and the inverted subtrahend slice
// for both possible carry-ins so the carry chain only has to pick a result.
// Ports:
//   a      in  BW  minuend slice
//   b_inv  in  BW  inverted subtrahend slice
//   sum0   out BW  a + b_inv       (carry-in 0)
//   sum1   out BW  a + b_inv + 1   (carry-in 1)
//   cout0  out 1   carry-out for carry-in 0
//   cout1  out 1   carry-out for carry-in 1
// ---------------------------------------------------------------------------
module csa_sub_blk #(
    parameter int BW = 2
) (
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b_inv,
    output logic [BW-1:0] sum0,
    output logic [BW-1:0] sum1,
    output logic          cout0,
    output logic          cout1
);

    assign {cout0, sum0} = {1'b0, a} + {1'b0, b_inv};
    assign {cout1, sum1} = {1'b0, a} + {1'b0, b_inv} + {{BW{1'b0}}, 1'b1};

endmodule

// File: rtl/csa_sub_pipe.sv
// ---------------------------------------------------------------------------
// csa_sub_pipe
// Two-stage valid/ready pipelined carry-select subtractor,
// diff = i_sub_term1 - i_sub_term2 computed as term1 + ~term2 + 1.
// Stage 1 registers the block sums for both carry-ins, stage 2 ripples the
// block carries, selects the sums and registers the result.
// Optional feature macro: OVF_FLAG_EN adds the signed-overflow output ovf.
// Requires WIDTH > BLK so at least one carry-select block exists.
// Ports:
//   clk          in  1      rising-edge clock
//   rst          in  1      synchronous active-high reset
//   in_valid     in  1      operand pair valid
//   in_ready     out 1      operand pair can be accepted this cycle
//   i_sub_term1  in  WIDTH  minuend
//   i_sub_term2  in  WIDTH  subtrahend
//   out_valid    out 1      diff/borrow valid
//   out_ready    in  1      downstream accepts result
//   diff         out WIDTH  (term1 - term2) mod 2^WIDTH
//   borrow       out 1      term1 < term2 (unsigned)
//   ovf          out 1      signed overflow (OVF_FLAG_EN only)
// ---------------------------------------------------------------------------
module csa_sub_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH_DEF,
    parameter int BLK   = CSA_BLK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i_sub_term1,
    input  logic [WIDTH-1:0] i_sub_term2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int LOW_W = BLK;
    localparam int UW    = WIDTH - BLK;
    localparam int NBLK  = csa_nblk(WIDTH, BLK);

    logic [WIDTH-1:0] b_inv;

    logic [LOW_W-1:0] low_sum_c;
    logic             low_cout_c;
    logic [LOW_W-1:0] low_sum0_unused;
    logic             low_cout0_unused;

    logic [UW-1:0]    up_sum0_c;
    logic [UW-1:0]    up_sum1_c;
    logic [NBLK-1:0]  up_cout0_c;
    logic [NBLK-1:0]  up_cout1_c;

    logic             s1_valid;
    logic [LOW_W-1:0] s1_low_sum;
    logic             s1_low_cout;
    logic [UW-1:0]    s1_sum0;
    logic [UW-1:0]    s1_sum1;
    logic [NBLK-1:0]  s1_cout0;
    logic [NBLK-1:0]  s1_cout1;
`ifdef OVF_FLAG_EN
    logic             s1_t1_msb;
    logic             s1_t2_msb;
    logic             ovf_c;
`endif

    logic             s2_valid;
    logic [WIDTH-1:0] diff_c;
    logic             borrow_c;

    logic             s1_adv;
    logic             s2_adv;

    assign b_inv = ~i_sub_term2;

    // The low block always sees the +1 of the two's-complement negate, so only
    // its carry-in-1 outputs matter.
    csa_sub_blk #(.BW(LOW_W)) u_low (
        .a     (i_sub_term1[LOW_W-1:0]),
        .b_inv (b_inv[LOW_W-1:0]),
        .sum0  (low_sum0_unused),
        .sum1  (low_sum_c),
        .cout0 (low_cout0_unused),
        .cout1 (low_cout_c)
    );

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        localparam int LSB = k * BLK;
        localparam int BW  = (k == NBLK - 1) ? (UW - LSB) : BLK;

        csa_sub_blk #(.BW(BW)) u_blk (
            .a     (i_sub_term1[LOW_W+LSB +: BW]),
            .b_inv (b_inv[LOW_W+LSB +: BW]),
            .sum0  (up_sum0_c[LSB +: BW]),
            .sum1  (up_sum1_c[LSB +: BW]),
            .cout0 (up_cout0_c[k]),
            .cout1 (up_cout1_c[k])
        );
    end

    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;
    assign out_valid = s2_valid;

    // Carry-select chain: each block picks sum0/sum1 from the carry entering it,
    // and the carry leaving the last block is the inverse of the borrow.
    always_comb begin : p_select
        logic c;
        int   k;
        c      = s1_low_cout;
        diff_c = '0;
        diff_c[LOW_W-1:0] = s1_low_sum;
        for (int i = 0; i < UW; i++) begin
            k = i / BLK;
            diff_c[LOW_W+i] = c ? s1_sum1[i] : s1_sum0[i];
            if ((i % BLK == BLK - 1) || (i == UW - 1)) begin
                c = c ? s1_cout1[k] : s1_cout0[k];
            end
        end
        borrow_c = ~c;
    end

`ifdef OVF_FLAG_EN
    assign ovf_c = (s1_t1_msb != s1_t2_msb) & (diff_c[WIDTH-1] != s1_t1_msb);
`endif

    // Each stage loads only when it advances; otherwise it holds, which keeps
    // the outputs stable under back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_low_sum  <= '0;
            s1_low_cout <= 1'b0;
            s1_sum0     <= '0;
            s1_sum1     <= '0;
            s1_cout0    <= '0;
            s1_cout1    <= '0;
            s2_valid    <= 1'b0;
            diff        <= '0;
            borrow      <= 1'b0;
`ifdef OVF_FLAG_EN
            s1_t1_msb   <= 1'b0;
            s1_t2_msb   <= 1'b0;
            ovf         <= 1'b0;
`endif
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_low_sum  <= low_sum_c;
                    s1_low_cout <= low_cout_c;
                    s1_sum0     <= up_sum0_c;
                    s1_sum1     <= up_sum1_c;
                    s1_cout0    <= up_cout0_c;
                    s1_cout1    <= up_cout1_c;
`ifdef OVF_FLAG_EN
                    s1_t1_msb   <= i_sub_term1[WIDTH-1];
                    s1_t2_msb   <= i_sub_term2[WIDTH-1];
`endif
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    diff   <= diff_c;
                    borrow <= borrow_c;
`ifdef OVF_FLAG_EN
                    ovf    <= ovf_c;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_csa_sub_pipe.sv
// ---------------------------------------------------------------------------
// tb_csa_sub_pipe
// Self-checking bench for csa_sub_pipe (WIDTH=5, BLK=2). A queue-based
// reference model predicts in_ready, out_valid and each result from plain
// integer arithmetic and the two-cycle latency / two-entry capacity of the
// pipeline. Honours OVF_FLAG_EN like the design.
// ---------------------------------------------------------------------------
module tb_csa_sub_pipe;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] i_sub_term1 = '0;
    logic [W-1:0] i_sub_term2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef OVF_FLAG_EN
    logic         ovf;
`endif

    csa_sub_pipe #(.WIDTH(W), .BLK(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .i_sub_term1 (i_sub_term1),
        .i_sub_term2 (i_sub_term2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .diff        (diff),
        .borrow      (borrow)
`ifdef OVF_FLAG_EN
        ,
        .ovf         (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        logic         o;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Compare one observed value against its expectation.
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference result from integer arithmetic on the operands.
    function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int ai, bi, sa, sb, sd;
        ai   = int'(a);
        bi   = int'(b);
        e.d  = W'((ai - bi) & 31);
        e.b  = (ai < bi);
        sa   = a[W-1] ? ai - 32 : ai;
        sb   = b[W-1] ? bi - 32 : bi;
        sd   = sa - sb;
        e.o  = (sd > 15) || (sd < -16);
        e.acc = 0;
        return e;
    endfunction

    // Drive one cycle from just after a falling edge, check the predicted
    // handshake and output state, then update the model at the rising edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ordy, output logic accepted);
        logic exp_ir, exp_ov, fire;
        exp_t e;
        rst         = 1'b0;
        in_valid    = v;
        i_sub_term1 = a;
        i_sub_term2 = b;
        out_ready   = ordy;
        #1;
        exp_ir = (q.size() < 2) || ordy;
        exp_ov = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        if (exp_ov) begin
            checkOutput("diff", {27'd0, diff}, {27'd0, q[0].d});
            checkOutput("borrow", {31'd0, borrow}, {31'd0, q[0].b});
`ifdef OVF_FLAG_EN
            checkOutput("ovf", {31'd0, ovf}, {31'd0, q[0].o});
`endif
        end
        fire     = exp_ov & ordy;
        accepted = v & exp_ir;
        @(posedge clk);
        if (fire) begin
            void'(q.pop_front());
        end
        if (accepted) begin
            e     = refModel(a, b);
            e.acc = cyc;
            q.push_back(e);
        end
        cyc++;
        @(negedge clk);
    endtask

    // Synchronous reset for one edge, then confirm the cleared state.
    task automatic applyReset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_diff", {27'd0, diff}, 32'd0);
        checkOutput("rst_borrow", {31'd0, borrow}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef OVF_FLAG_EN
        checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    endtask

    // Idle with out_ready high until the model is empty, bounded.
    task automatic drain();
        logic acc;
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, acc);
        end
        checkOutput("drain_empty", q.size(), 32'd0);
    endtask

    // Issue one op with out_ready high, retrying until accepted (bounded).
    task automatic sendOp(input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            applyStimulus(1'b1, a, b, 1'b1, acc);
        end
        checkOutput("send_accepted", {31'd0, acc}, 32'd1);
    endtask

    initial begin : main
        logic acc;
        int   idx;
        int   guard;
        logic [W-1:0] ops_a [4];
        logic [W-1:0] ops_b [4];
        logic bp_rdy [12];

        @(negedge clk);
        applyReset();

        // Directed arithmetic cases, including the borrow and wrap boundaries.
        sendOp(5'd9, 5'd3);
        drain();
        sendOp(5'd3, 5'd9);
        sendOp(5'd0, 5'd0);
        sendOp(5'd31, 5'd31);
        sendOp(5'd0, 5'd31);
        sendOp(5'd31, 5'd0);
        drain();
`ifdef OVF_FLAG_EN
        sendOp(5'd16, 5'd1);
        sendOp(5'd15, 5'd31);
        sendOp(5'd5, 5'd3);
        drain();
`endif

        // Back-pressure: four ops streamed while the sink stalls for 3 cycles.
        ops_a = '{5'd20, 5'd4, 5'd17, 5'd1};
        ops_b = '{5'd7, 5'd11, 5'd17, 5'd30};
        bp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            if (idx < 4) begin
                applyStimulus(1'b1, ops_a[idx], ops_b[idx], bp_rdy[c], acc);
                if (acc) idx++;
            end else begin
                applyStimulus(1'b0, '0, '0, bp_rdy[c], acc);
            end
        end
        checkOutput("bp_all_sent", idx, 32'd4);
        drain();

        // Reset with both stages occupied, then confirm normal operation.
        applyStimulus(1'b1, 5'd12, 5'd5, 1'b0, acc);
        applyStimulus(1'b1, 5'd6, 5'd9, 1'b0, acc);
        applyStimulus(1'b1, 5'd8, 5'd8, 1'b0, acc);
        applyReset();
        sendOp(5'd7, 5'd2);
        drain();

        // Every operand pair, random valid and ready.
        idx   = 0;
        guard = 0;
        while (idx < 1024 && guard < 20000) begin
            logic [9:0] p;
            p = idx[9:0];
            applyStimulus(($urandom_range(0, 3) != 0), p[9:5], p[4:0],
                          ($urandom_range(0, 3) != 0), acc);
            if (acc) idx++;
            guard++;
        end
        checkOutput("exhaustive_done", idx, 32'd1024);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
